// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller driving one shared BCD-to-7-segment decoder across NDIGITS digits.
// Double-buffered frame with tear-free commit, anti-ghosting blank interval and 8-level brightness gating.
module seg7_scan_ctrl #(
    parameter int unsigned NDIGITS      = 4,
    parameter int unsigned REFRESH_BITS = 12,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_wr_en,
    input  logic [2:0]         i_wr_idx,
    input  logic [4:0]         i_wr_val,
    input  logic               i_commit,
    input  logic [2:0]         i_bright,
    output logic [3:0]         o_val,
    output logic               o_dec,
    output logic [NDIGITS-1:0] o_digit_en,
    output logic               o_frame_start,
    output logic               o_commit_pending
);
    localparam int unsigned IDX_W = $clog2(NDIGITS);
    localparam int unsigned DIG_W = 5;

    localparam logic [REFRESH_BITS-1:0] T_MAX    = '1;
    localparam logic [REFRESH_BITS-1:0] T_BLANK  = REFRESH_BITS'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NDIGITS - 1);
    localparam logic [3:0]              NDIG_4   = 4'(NDIGITS);

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_OFF   = 2'd2;

    logic                          run_q;
    logic [REFRESH_BITS-1:0]       t_q, t_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [1:0]                    state_q, state_d;
    logic [NDIGITS-1:0][DIG_W-1:0] shadow_q, active_q, active_d;
    logic                          pending_d;
    logic                          boundary, load, wr_ok, gate;
    logic [NDIGITS-1:0]            en_d;
    logic [DIG_W-1:0]              digit_d;
    logic                          fs_d;

    // Next-state and registered-output computation; outputs describe the cycle after the edge.
    always_comb begin
        t_d       = t_q;
        idx_d     = idx_q;
        active_d  = active_q;
        pending_d = o_commit_pending;
        state_d   = ST_BLANK;
        en_d      = '0;
        digit_d   = {o_dec, o_val};

        // The first edge after reset only arms the scan, so cycle 0 shows t = 0, idx = 0.
        if (run_q) begin
            t_d = t_q + REFRESH_BITS'(1);
            if (t_q == T_MAX) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
        end

        boundary = run_q && (t_q == T_MAX) && (idx_q == IDX_LAST);
        load     = boundary && (o_commit_pending || i_commit);
        wr_ok    = i_wr_en && ({1'b0, i_wr_idx} < NDIG_4);

        if (load) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (i_commit) begin
            pending_d = 1'b1;
        end

        gate = (t_d[REFRESH_BITS-1 -: 3] <= i_bright);
        case (state_q)
            ST_BLANK: begin
                if (t_d >= T_BLANK) state_d = gate ? ST_ON : ST_OFF;
                else                state_d = ST_BLANK;
            end
            ST_ON, ST_OFF: begin
                if (t_d < T_BLANK) state_d = ST_BLANK;
                else               state_d = gate ? ST_ON : ST_OFF;
            end
            default: state_d = ST_BLANK;
        endcase

        if (state_d == ST_ON) en_d = NDIGITS'(1) << idx_d;

        // Decoder inputs change only at slot start, well ahead of the enable.
        if (t_d == '0) digit_d = active_d[idx_d];

        fs_d = (t_d == '0) && (idx_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_q            <= 1'b0;
            t_q              <= '0;
            idx_q            <= '0;
            state_q          <= ST_BLANK;
            shadow_q         <= '0;
            active_q         <= '0;
            o_commit_pending <= 1'b0;
            o_digit_en       <= '0;
            o_val            <= '0;
            o_dec            <= 1'b0;
            o_frame_start    <= 1'b0;
        end else begin
            run_q            <= 1'b1;
            t_q              <= t_d;
            idx_q            <= idx_d;
            state_q          <= state_d;
            active_q         <= active_d;
            o_commit_pending <= pending_d;
            o_digit_en       <= en_d;
            o_val            <= digit_d[3:0];
            o_dec            <= digit_d[4];
            o_frame_start    <= fs_d;
            if (wr_ok) shadow_q[IDX_W'(i_wr_idx)] <= i_wr_val;
        end
    end

endmodule
